// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
//   Device-side model of a 4x4 matrix keypad that performs one key press per
//   request. It watches the scanner's active-high row strobes and pulls the
//   matching active-low column line low, as a closed switch would. Optional
//   pseudo-random contact bounce is applied on press and on release.
//
// Ports
//   clk6MHz  in   1  system clock
//   rstn     in   1  synchronous, active-low reset
//   start_i  in   1  press request, accepted when start_i && ready_o
//   key_i    in   4  hex key code, sampled on the accept cycle
//   row_i    in   4  row strobes from the scanner, active-high
//   col_o    out  4  column lines to the scanner, active-low (4'hF = open)
//   ready_o  out  1  high only in IDLE
//   busy_o   out  1  high in every state except IDLE
//   done_o   out  1  one-cycle pulse when the release phase completes
// ---------------------------------------------------------------------------
module keypad_emulator #(
  parameter int unsigned HOLD_CYC   = 60000,
  parameter int unsigned BOUNCE_CYC = 3000,
  parameter int unsigned BOUNCE_EN  = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk6MHz,
  input  logic       rstn,
  input  logic       start_i,
  input  logic [3:0] key_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned MAX_CYC   = (HOLD_CYC > BOUNCE_CYC) ? HOLD_CYC : BOUNCE_CYC;
  localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);
  localparam bit          BOUNCE_ON = (BOUNCE_EN != 0) && (BOUNCE_CYC != 0);
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_step;
  logic [1:0]       r_row;
  logic [1:0]       r_col;
  logic [1:0]       w_key_row;
  logic [1:0]       w_key_col;
  logic             w_accept;
  logic             w_contact;
  logic             w_bouncing;
  logic [3:0]       w_col_drive;
  logic [3:0]       r_col_o;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  assign col_o   = r_col_o;
  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

  // Key code to matrix position (row r, column c)
  always_comb begin
    w_key_row = 2'd0;
    w_key_col = 2'd0;
    case (key_i)
      4'h1: begin w_key_row = 2'd0; w_key_col = 2'd0; end
      4'h2: begin w_key_row = 2'd0; w_key_col = 2'd1; end
      4'h3: begin w_key_row = 2'd0; w_key_col = 2'd2; end
      4'hA: begin w_key_row = 2'd0; w_key_col = 2'd3; end
      4'h4: begin w_key_row = 2'd1; w_key_col = 2'd0; end
      4'h5: begin w_key_row = 2'd1; w_key_col = 2'd1; end
      4'h6: begin w_key_row = 2'd1; w_key_col = 2'd2; end
      4'hB: begin w_key_row = 2'd1; w_key_col = 2'd3; end
      4'h7: begin w_key_row = 2'd2; w_key_col = 2'd0; end
      4'h8: begin w_key_row = 2'd2; w_key_col = 2'd1; end
      4'h9: begin w_key_row = 2'd2; w_key_col = 2'd2; end
      4'hC: begin w_key_row = 2'd2; w_key_col = 2'd3; end
      4'hE: begin w_key_row = 2'd3; w_key_col = 2'd0; end
      4'h0: begin w_key_row = 2'd3; w_key_col = 2'd1; end
      4'hF: begin w_key_row = 2'd3; w_key_col = 2'd2; end
      4'hD: begin w_key_row = 2'd3; w_key_col = 2'd3; end
      default: begin w_key_row = 2'd0; w_key_col = 2'd0; end
    endcase
  end

  // Next state and phase counter; the counter holds the cycles left in the phase
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && r_ready) begin
          w_accept = 1'b1;
          if (BOUNCE_ON) begin
            w_state_nxt = S_BOUNCE_IN;
            w_cnt_nxt   = CNT_W'(BOUNCE_CYC);
          end else begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = CNT_W'(HOLD_CYC);
          end
        end
      end
      S_BOUNCE_IN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CNT_W'(HOLD_CYC);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == CNT_W'(1)) begin
          if (BOUNCE_ON) begin
            w_state_nxt = S_BOUNCE_OUT;
            w_cnt_nxt   = CNT_W'(BOUNCE_CYC);
          end else begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = CNT_W'(0);
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_BOUNCE_OUT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = CNT_W'(0);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_W'(0);
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_W'(0);
      end
    endcase
  end

  // Switch contact: solid in HOLD, LFSR-driven chatter while bouncing
  always_comb begin
    w_bouncing  = (r_state == S_BOUNCE_IN) || (r_state == S_BOUNCE_OUT);
    w_contact   = 1'b0;
    if (r_state == S_HOLD) begin
      w_contact = 1'b1;
    end else if (w_bouncing) begin
      w_contact = r_lfsr[0];
    end
    w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ ({16{r_lfsr[0]}} & LFSR_TAPS);
    // Only the latched row strobe matters; other rows never affect the column
    w_col_drive = (w_contact && row_i[r_row]) ? (4'b0001 << r_col) : 4'b0000;
  end

  // State, counter, LFSR and registered outputs
  always_ff @(posedge clk6MHz) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_W'(0);
      r_lfsr  <= LFSR_SEED;
      r_row   <= 2'd0;
      r_col   <= 2'd0;
      r_col_o <= 4'hF;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_bouncing) begin
        r_lfsr <= w_lfsr_step;
      end
      if (w_accept) begin
        r_row <= w_key_row;
        r_col <= w_key_col;
      end
      r_col_o <= ~w_col_drive;
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_emulator
//   Directed bench for keypad_emulator. Two instances: one with bouncing off
//   (HOLD 8) and one with bouncing on (BOUNCE 16, HOLD 32). Outputs are
//   sampled on the falling edge; inputs are also changed there.
// ---------------------------------------------------------------------------
module tb_keypad_emulator;

  localparam int unsigned HOLD_NB = 8;
  localparam int unsigned HOLD_B  = 32;
  localparam int unsigned BNC_B   = 16;

  logic       clk6MHz;
  logic       rstn;
  logic       start_nb, start_b;
  logic [3:0] key_nb, key_b;
  logic [3:0] row_nb, row_b;
  logic [3:0] col_nb, col_b;
  logic       ready_nb, ready_b;
  logic       busy_nb, busy_b;
  logic       done_nb, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Row-major key layout of the keypad: index = r*4 + c
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  keypad_emulator #(.HOLD_CYC(HOLD_NB), .BOUNCE_CYC(16), .BOUNCE_EN(0),
                    .LFSR_SEED(16'hACE1)) u_dut_nb (
    .clk6MHz(clk6MHz), .rstn(rstn), .start_i(start_nb), .key_i(key_nb),
    .row_i(row_nb), .col_o(col_nb), .ready_o(ready_nb), .busy_o(busy_nb),
    .done_o(done_nb));

  keypad_emulator #(.HOLD_CYC(HOLD_B), .BOUNCE_CYC(BNC_B), .BOUNCE_EN(1),
                    .LFSR_SEED(16'hACE1)) u_dut_b (
    .clk6MHz(clk6MHz), .rstn(rstn), .start_i(start_b), .key_i(key_b),
    .row_i(row_b), .col_o(col_b), .ready_o(ready_b), .busy_o(busy_b),
    .done_o(done_b));

  initial clk6MHz = 1'b0;
  always #5 clk6MHz = ~clk6MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // One press on the no-bounce instance; rows fixed at the key's row or walking
  task automatic press_nb(input logic [3:0] key, input bit walk);
    int r = 0, c = 0;
    logic [3:0] row, exp_col, decoded;
    bit got;
    for (int i = 0; i < 16; i++) if (keymap[i] == key) begin r = i / 4; c = i % 4; end
    got = 1'b0;
    decoded = 4'h0;
    @(negedge clk6MHz);
    chk("nb_ready_pre", ready_nb, 1);
    start_nb = 1'b1;
    key_nb   = key;
    row      = walk ? 4'b0001 : (4'b0001 << r);
    row_nb   = row;
    exp_col  = 4'hF;
    for (int k = 1; k <= int'(HOLD_NB) + 3; k++) begin
      @(negedge clk6MHz);
      if (k == 1) begin
        start_nb = 1'b0;
        key_nb   = 4'h0;
        chk("nb_busy", busy_nb, 1);
      end
      chk("nb_col", col_nb, exp_col);
      chk("nb_done", done_nb, (k == int'(HOLD_NB) + 1));
      // Scanner side: decode from the row strobed on the previous cycle
      if (col_nb != 4'hF) begin
        decoded = keymap[onehot_idx(row) * 4 + onehot_idx(~col_nb)];
        got     = 1'b1;
      end
      if (walk) row = {row[2:0], row[3]};
      row_nb  = row;
      exp_col = (k <= int'(HOLD_NB) && row[r]) ? ~(4'b0001 << c) : 4'hF;
    end
    chk("nb_ready_post", ready_nb, 1);
    chk("nb_decode_seen", got, 1);
    chk("nb_decode", decoded, key);
  endtask

  // One press of key D on the bounce instance with the LFSR predicted locally
  task automatic press_b();
    logic [15:0] lfsr;
    logic [3:0]  exp_col;
    logic        ct;
    bit hi1, lo1, hi2, lo2;
    int last;
    lfsr = 16'hACE1;
    hi1 = 0; lo1 = 0; hi2 = 0; lo2 = 0;
    last = int'(HOLD_B + 2 * BNC_B) + 3;
    @(negedge clk6MHz);
    start_b = 1'b1;
    key_b   = 4'hD;
    row_b   = 4'b1000;
    exp_col = 4'hF;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk6MHz);
      if (k == 1) start_b = 1'b0;
      chk("b_col", col_b, exp_col);
      chk("b_done", done_b, (k == int'(HOLD_B + 2 * BNC_B) + 1));
      if (k == 30) chk("b_busy", busy_b, 1);
      if (k >= 2 && k <= int'(BNC_B) + 1) begin
        if (col_b == 4'hF) hi1 = 1; else lo1 = 1;
      end
      if (k >= int'(BNC_B + HOLD_B) + 2 && k <= int'(2 * BNC_B + HOLD_B) + 1) begin
        if (col_b == 4'hF) hi2 = 1; else lo2 = 1;
      end
      // Contact during cycle k, which shows on col_b one cycle later
      if (k <= int'(BNC_B) ||
          (k > int'(BNC_B + HOLD_B) && k <= int'(2 * BNC_B + HOLD_B))) begin
        ct   = lfsr[0];
        lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end else if (k <= int'(BNC_B + HOLD_B)) begin
        ct = 1'b1;
      end else begin
        ct = 1'b0;
      end
      exp_col = ct ? 4'b0111 : 4'hF;
    end
    chk("b_bounce_in_toggles", {hi1, lo1}, 2'b11);
    chk("b_bounce_out_toggles", {hi2, lo2}, 2'b11);
    chk("b_ready_post", ready_b, 1);
  endtask

  initial begin
    int dones_first, dones_after;
    rstn = 1'b0;
    start_nb = 1'b0; key_nb = 4'h0; row_nb = 4'h0;
    start_b  = 1'b0; key_b  = 4'h0; row_b  = 4'h0;

    // Reset held for three cycles, then released
    repeat (3) begin
      @(negedge clk6MHz);
      chk("rst_col_nb", col_nb, 4'hF);
      chk("rst_col_b", col_b, 4'hF);
      chk("rst_ready", ready_nb, 0);
      chk("rst_busy", busy_nb, 0);
      chk("rst_done", done_nb, 0);
    end
    rstn = 1'b1;
    @(negedge clk6MHz);
    chk("post_rst_ready", ready_nb, 1);
    chk("post_rst_ready_b", ready_b, 1);
    chk("post_rst_col", col_nb, 4'hF);
    chk("post_rst_done", done_nb, 0);

    // Key 5 with its row strobed continuously, then with walking rows
    press_nb(4'h5, 1'b0);
    press_nb(4'h5, 1'b1);

    // Bounce instance, key D
    press_b();

    // start_i held high: one press, re-accept right after done_o, then reset mid-HOLD
    @(negedge clk6MHz);
    start_nb = 1'b1; key_nb = 4'h5; row_nb = 4'b0010;
    dones_first = 0; dones_after = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk6MHz);
      if (k <= 10) dones_first += int'(done_nb); else dones_after += int'(done_nb);
      if (k == 9)  chk("hold_done_pulse", done_nb, 1);
      if (k == 10) begin
        chk("hold_ready_idle", ready_nb, 1);
        chk("hold_one_done", dones_first, 1);
      end
      if (k == 11) begin
        chk("hold_reaccept_busy", busy_nb, 1);
        start_nb = 1'b0;
      end
      if (k == 14) begin
        chk("hold_col_pressed", col_nb, 4'b1101);
        rstn = 1'b0;
      end
      if (k == 15) begin
        chk("midrst_col", col_nb, 4'hF);
        chk("midrst_ready", ready_nb, 0);
        chk("midrst_busy", busy_nb, 0);
        rstn = 1'b1;
      end
      if (k == 16) chk("midrst_ready_back", ready_nb, 1);
      if (k >= 16) chk("midrst_col_idle", col_nb, 4'hF);
    end
    chk("midrst_no_done", dones_after, 0);

    // Every key through the scanner path
    for (int i = 0; i < 16; i++) press_nb(4'(i), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
